// File: rtl/pc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pc_seq_ctrl
//   Next-PC sequencer for the pipelined MIPS core. Each cycle it arbitrates
//   between redirect sources (EX branch, illegal opcode, pending interrupt,
//   ID jr/jump, load-use stall) and drives the PC source select, PC write
//   enable, pipeline flushes and EPC capture controls. After an interrupt or
//   exception redirect a holdoff counter blocks new irq/illop for HOLDOFF
//   cycles.
//
//   Optional feature macro: PCSEQ_IRQ_EDGE_EN
//     defined   : irq is registered and only a rising edge pends an interrupt;
//                 edges seen in kernel mode are remembered until user mode.
//     undefined : irq is level sensitive.
//
//   Ports
//     clk             core clock
//     reset           synchronous active-low reset
//     irq             external interrupt request
//     illop_id        undefined opcode decoded in ID
//     branch_taken_ex conditional branch in EX resolved taken
//     jump_id         J/JAL in ID
//     jr_id           JR/JALR in ID
//     stall_lu        load-use stall request
//     kernel_id       PC[31] of the ID instruction (1 = kernel mode)
//     pc_src          0 PC+4, 1 branch, 2 jump, 3 register, 4 irq vec, 5 exc vec
//     pc_we           PC register write enable
//     flush_if        clear IF/ID register
//     flush_id        clear ID/EX register
//     epc_we          capture return address into EPC
//     epc_sel         0 = PC of ID instr, 1 = PC of ID instr + 4
//     irq_ack         one-cycle pulse when the interrupt redirect is issued
//     irq_pend        pending-interrupt flag (registered)
//
//   Only irq_pend and the internal state are registered; all other outputs
//   are combinational from the inputs and the current state.
// -----------------------------------------------------------------------------
module pc_seq_ctrl #(
  parameter int unsigned HOLDOFF = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       irq,
  input  logic       illop_id,
  input  logic       branch_taken_ex,
  input  logic       jump_id,
  input  logic       jr_id,
  input  logic       stall_lu,
  input  logic       kernel_id,
  output logic [2:0] pc_src,
  output logic       pc_we,
  output logic       flush_if,
  output logic       flush_id,
  output logic       epc_we,
  output logic       epc_sel,
  output logic       irq_ack,
  output logic       irq_pend
);

  localparam logic [2:0] PC_SEQ  = 3'd0;
  localparam logic [2:0] PC_BR   = 3'd1;
  localparam logic [2:0] PC_J    = 3'd2;
  localparam logic [2:0] PC_JR   = 3'd3;
  localparam logic [2:0] PC_IRQ  = 3'd4;
  localparam logic [2:0] PC_EXC  = 3'd5;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // RUN <=> holdoff counter is zero; HOLD <=> counter is non-zero.
  typedef enum logic {
    S_RUN  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             pend_set;
  logic             take_exc;

  assign irq_pend = pend_q;

`ifdef PCSEQ_IRQ_EDGE_EN
  // Rising-edge interrupt detection; edges arriving in kernel mode are held
  // in kmem_q and delivered once the ID instruction is back in user mode.
  logic irq_q;
  logic kmem_q, kmem_d;
  logic irq_rise;

  always_comb begin
    irq_rise = irq & ~irq_q;
    pend_set = ~kernel_id & (irq_rise | kmem_q);
    kmem_d   = kernel_id & (kmem_q | irq_rise);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_q  <= 1'b0;
      kmem_q <= 1'b0;
    end else begin
      irq_q  <= irq;
      kmem_q <= kmem_d;
    end
  end
`else
  // Level-sensitive: a held irq re-pends as soon as the holdoff expires.
  always_comb begin
    pend_set = irq & ~kernel_id;
  end
`endif

  // State, holdoff counter and pending latch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Redirect arbitration, output decode and next-state logic.
  always_comb begin
    pc_src   = PC_SEQ;
    pc_we    = 1'b1;
    flush_if = 1'b0;
    flush_id = 1'b0;
    epc_we   = 1'b0;
    epc_sel  = 1'b0;
    irq_ack  = 1'b0;
    take_exc = 1'b0;
    cnt_d    = cnt_q;
    state_d  = state_q;
    pend_d   = pend_q;

    if (reset) begin
      if (branch_taken_ex) begin
        // The ID instruction is squashed, so its illop/jump are moot.
        pc_src   = PC_BR;
        flush_if = 1'b1;
        flush_id = 1'b1;
      end else if (illop_id && (state_q == S_RUN)) begin
        pc_src   = PC_EXC;
        flush_if = 1'b1;
        epc_we   = 1'b1;
        epc_sel  = 1'b1;
        take_exc = 1'b1;
      end else if (pend_q && (state_q == S_RUN) && !kernel_id && !stall_lu &&
                   !jump_id && !jr_id) begin
        // Deferred behind jumps so EPC never lands in the discarded delay slot.
        pc_src   = PC_IRQ;
        flush_if = 1'b1;
        epc_we   = 1'b1;
        epc_sel  = 1'b0;
        irq_ack  = 1'b1;
        take_exc = 1'b1;
      end else if (jr_id) begin
        pc_src   = PC_JR;
        flush_if = 1'b1;
      end else if (jump_id) begin
        pc_src   = PC_J;
        flush_if = 1'b1;
      end else if (stall_lu) begin
        pc_we    = 1'b0;
        flush_id = 1'b1;
      end

      if (take_exc) begin
        cnt_d = HOLD_LOAD;
      end else if (state_q == S_HOLD) begin
        cnt_d = cnt_q - CNT_ONE;
      end

      state_d = (cnt_d != '0) ? S_HOLD : S_RUN;
      pend_d  = irq_ack ? 1'b0 : (pend_q | pend_set);
    end
  end

  // Design invariants.
  a_pc_src_range : assert property (@(posedge clk) disable iff (!reset)
    pc_src <= PC_EXC);
  a_state_cnt    : assert property (@(posedge clk) disable iff (!reset)
    (state_q == S_HOLD) == (cnt_q != '0));
  a_ack_needs_pend : assert property (@(posedge clk) disable iff (!reset)
    irq_ack |-> pend_q);

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_seq_ctrl
//   Scoreboard bench for pc_seq_ctrl. A driver applies directed and random
//   stimulus at the falling edge, evaluates a behavioural model of the
//   arbitration rules and pushes the expected outputs into a queue; a monitor
//   pops and compares shortly after each falling edge.
// -----------------------------------------------------------------------------
module tb_pc_seq_ctrl;

  localparam int unsigned HOLDOFF = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int          N_RAND  = 3000;

  logic       clk;
  logic       reset;
  logic       irq;
  logic       illop_id;
  logic       branch_taken_ex;
  logic       jump_id;
  logic       jr_id;
  logic       stall_lu;
  logic       kernel_id;
  logic [2:0] pc_src;
  logic       pc_we;
  logic       flush_if;
  logic       flush_id;
  logic       epc_we;
  logic       epc_sel;
  logic       irq_ack;
  logic       irq_pend;

  typedef struct packed {
    logic [2:0] src;
    logic       we;
    logic       fif;
    logic       fid;
    logic       epc;
    logic       sel;
    logic       ack;
    logic       pend;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   running  = 1'b0;
  int   cyc      = 0;

  // Behavioural model state (values visible during the current cycle).
  bit m_pend;
  int m_hold;
  bit m_irq_prev;
  bit m_kmem;

  pc_seq_ctrl #(.HOLDOFF(HOLDOFF), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .irq             (irq),
    .illop_id        (illop_id),
    .branch_taken_ex (branch_taken_ex),
    .jump_id         (jump_id),
    .jr_id           (jr_id),
    .stall_lu        (stall_lu),
    .kernel_id       (kernel_id),
    .pc_src          (pc_src),
    .pc_we           (pc_we),
    .flush_if        (flush_if),
    .flush_id        (flush_id),
    .epc_we          (epc_we),
    .epc_sel         (epc_sel),
    .irq_ack         (irq_ack),
    .irq_pend        (irq_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, predict the outputs, advance the model.
  task automatic step(input bit r, input bit i, input bit il, input bit br,
                      input bit j, input bit jr, input bit st, input bit k);
    obs_t e;
    bit   excep;
    bit   setp;
    bit   rise;
    @(negedge clk);
    reset = r; irq = i; illop_id = il; branch_taken_ex = br;
    jump_id = j; jr_id = jr; stall_lu = st; kernel_id = k;
    running = 1'b1;
    cyc++;

    e = '0;
    e.we   = 1'b1;
    e.pend = m_pend;
    excep  = 1'b0;
    if (r) begin
      if (br) begin
        e.src = 3'd1; e.fif = 1'b1; e.fid = 1'b1;
      end else if (il && m_hold == 0) begin
        e.src = 3'd5; e.fif = 1'b1; e.epc = 1'b1; e.sel = 1'b1; excep = 1'b1;
      end else if (m_pend && m_hold == 0 && !k && !st && !j && !jr) begin
        e.src = 3'd4; e.fif = 1'b1; e.epc = 1'b1; e.ack = 1'b1; excep = 1'b1;
      end else if (jr) begin
        e.src = 3'd3; e.fif = 1'b1;
      end else if (j) begin
        e.src = 3'd2; e.fif = 1'b1;
      end else if (st) begin
        e.we = 1'b0; e.fid = 1'b1;
      end
    end
    exp_q.push_back(e);

    if (!r) begin
      m_pend = 1'b0; m_hold = 0; m_irq_prev = 1'b0; m_kmem = 1'b0;
    end else begin
`ifdef PCSEQ_IRQ_EDGE_EN
      rise = i && !m_irq_prev;
      setp = !k && (rise || m_kmem);
      m_kmem = k && (m_kmem || rise);
      m_irq_prev = i;
`else
      rise = 1'b0;
      setp = i && !k;
`endif
      if (e.ack) m_pend = 1'b0;
      else if (setp) m_pend = 1'b1;
      if (excep) m_hold = HOLDOFF;
      else if (m_hold > 0) m_hold = m_hold - 1;
    end
  endtask

  task automatic idle(input int n, input bit k);
    for (int c = 0; c < n; c++) step(1, 0, 0, 0, 0, 0, 0, k);
  endtask

  // Monitor: compare DUT outputs against the oldest prediction.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = '{src: pc_src, we: pc_we, fif: flush_if, fid: flush_id,
              epc: epc_we, sel: epc_sel, ack: irq_ack, pend: irq_pend};
        if (!e.epc) begin
          a.sel = 1'b0;
          e.sel = 1'b0;
        end
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs cycle=%0d got src=%0d we=%b fif=%b fid=%b epc=%b sel=%b ack=%b pend=%b want src=%0d we=%b fif=%b fid=%b epc=%b sel=%b ack=%b pend=%b",
                   cyc, a.src, a.we, a.fif, a.fid, a.epc, a.sel, a.ack, a.pend,
                   e.src, e.we, e.fif, e.fid, e.epc, e.sel, e.ack, e.pend);
        end
      end else if (running) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty cycle=%0d got queue=0 want queue>=1", cyc);
      end
    end
  end

  // Driver: directed scenarios followed by random traffic.
  initial begin
    bit k;
    bit i;
    reset = 1'b0; irq = 1'b1; illop_id = 1'b0; branch_taken_ex = 1'b0;
    jump_id = 1'b0; jr_id = 1'b0; stall_lu = 1'b0; kernel_id = 1'b0;
    m_pend = 1'b0; m_hold = 0; m_irq_prev = 1'b0; m_kmem = 1'b0;
    @(posedge clk);

    // Reset held with irq high, then release: pend next cycle, then ack.
    for (int c = 0; c < 3; c++) step(0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(4, 0);

    // Branch beats illop; next cycle no exception.
    step(1, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // Illop holdoff window.
    for (int c = 0; c < 4; c++) step(1, 0, 1, 0, 0, 0, 0, 0);
    idle(3, 0);

    // Pending interrupt deferred by stall and by jump.
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(3, 0);

    // Kernel mode masks irq; dropping kernel lets it through.
    for (int c = 0; c < 10; c++) step(1, 1, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(3, 0);

    // jr beats jump; plain stall bubble.
    step(1, 0, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    idle(2, 0);

    // Held irq re-pends after the holdoff.
    for (int c = 0; c < 8; c++) step(1, 1, 0, 0, 0, 0, 0, 0);
    idle(4, 0);

    // Random traffic with sticky irq and kernel levels.
    k = 1'b0;
    i = 1'b0;
    for (int n = 0; n < N_RAND; n++) begin
      if ($urandom_range(0, 99) < 6)  k = ~k;
      if ($urandom_range(0, 99) < 15) i = ~i;
      step($urandom_range(0, 99) >= 2,
           i,
           $urandom_range(0, 99) < 12,
           $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 12,
           $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 15,
           k);
    end

    @(negedge clk);
    running = 1'b0;
    @(negedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got leftover=%0d want leftover=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Sequencer for the next-PC selector in the pipelined MIPS core.
- Each cycle it resolves competing redirect sources and drives the 3-bit PC source select plus PC write enable:
  - EX-stage branch, ID-stage jump/jr, illegal opcode, external interrupt, load-use stall.
- Also generates pipeline flushes and EPC capture, and holds a pending interrupt until a safe cycle.
- Sits beside the hazard unit in the ID/EX control path.

Parameters:
- HOLDOFF, 2, cycles after any interrupt/exception redirect during which new irq/illop are not taken (range 1..15).
- CNT_W, 4, width of the holdoff counter.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-low reset
- irq  in  1  external interrupt request (level)
- illop_id  in  1  undefined opcode decoded in ID
- branch_taken_ex  in  1  conditional branch in EX resolved taken
- jump_id  in  1  J/JAL in ID
- jr_id  in  1  JR/JALR in ID
- stall_lu  in  1  load-use stall request from hazard unit
- kernel_id  in  1  PC[31] of instruction in ID (1 = kernel mode)
- pc_src  out  3  0 PC+4, 1 branch target, 2 jump target, 3 register target, 4 interrupt vector 0x80000004, 5 exception vector 0x80000008
- pc_we  out  1  PC register write enable
- flush_if  out  1  clear IF/ID register
- flush_id  out  1  clear ID/EX register
- epc_we  out  1  capture return address into EPC/$26
- epc_sel  out  1  0 = EPC gets PC of ID instr (irq), 1 = PC of ID instr + 4 (illop)
- irq_ack  out  1  one-cycle pulse when interrupt redirect is issued
- irq_pend  out  1  pending-interrupt flag (status visibility)

Behaviour:
- All outputs are registered only where stated: irq_pend and the holdoff counter are flops; the other outputs are combinational from the inputs and state, evaluated each cycle.
- Reset (reset=0 at posedge):
  - State to RUN; irq_pend=0; holdoff counter=0.
  - While reset is low, combinational outputs are forced to: pc_src=0, pc_we=1, flush_if=0, flush_id=0, epc_we=0, irq_ack=0.
- States: RUN (counter==0) and HOLD (counter!=0).
- Pending latch:
  - irq=1 and kernel_id=0 sets irq_pend next cycle.
  - Cleared on the cycle irq_ack is issued.
  - Never set while kernel_id=1.
- Priority per cycle, highest first:
  1. branch_taken_ex: pc_src=1, flush_if=1, flush_id=1, pc_we=1. Overrides ID-stage events; the flushed ID instr is discarded and its illop/jump ignored. A pending irq stays pending.
  2. illop_id in RUN: pc_src=5, flush_if=1, epc_we=1, epc_sel=1, pc_we=1; load counter=HOLDOFF. Taken regardless of kernel_id.
  3. irq_pend in RUN, kernel_id=0, stall_lu=0: pc_src=4, flush_if=1, epc_we=1, epc_sel=0, irq_ack=1, pc_we=1; load counter=HOLDOFF; irq_pend cleared.
     - If jump_id/jr_id is also asserted that cycle, the interrupt is deferred one cycle (jump taken first) so EPC never points into a discarded slot.
  4. jr_id: pc_src=3, flush_if=1, pc_we=1.
  5. jump_id: pc_src=2, flush_if=1, pc_we=1.
  6. stall_lu: pc_we=0, pc_src=0, flush_id=1 (bubble).
  7. Otherwise: pc_src=0, pc_we=1.
- HOLD: counter decrements by 1 per cycle to 0, then the block returns to RUN.
  - In HOLD, illop_id and irq_pend are not acted on; irq_pend may still set.
  - Items 1, 4–7 operate normally.
- jr_id and jump_id both asserted (illegal decode): jr wins.
- Only the values 0–5 are ever driven on pc_src.
- Latency:
  - Redirect select is same-cycle combinational.
  - irq to irq_pend: 1 cycle.
  - irq_pend to irq_ack: 0 cycles when eligible.

Optional Feature:
- Macro: PCSEQ_IRQ_EDGE_EN.
- Defined: irq is registered and only a 0→1 edge sets irq_pend. Edges seen while kernel_id=1 are remembered and set irq_pend on return to user mode.
- Undefined: level-sensitive as above. irq held high re-pends after HOLDOFF whenever kernel_id=0.

Test Plan:
- Reset: hold reset=0 for 3 cycles with irq=1 → pc_src=0, pc_we=1, irq_pend=0, irq_ack=0. Release → irq_pend=1 one cycle later, then irq_ack pulse with pc_src=4, epc_sel=0.
- Branch vs illop: branch_taken_ex=1 and illop_id=1 in the same cycle → pc_src=1, flush_if=flush_id=1, epc_we=0. Next cycle (illop_id=0) → pc_src=0, no exception.
- Illop holdoff (HOLDOFF=2): illop_id pulse → pc_src=5, epc_we=1, epc_sel=1. illop_id again on the next 2 cycles → ignored (pc_src=0). On the 3rd cycle → pc_src=5.
- Interrupt vs stall/jump: irq_pend=1 with stall_lu=1 → pc_we=0, no ack. Then jump_id=1 → pc_src=2, no ack. Then a plain cycle → pc_src=4, irq_ack=1.
- Kernel mask: kernel_id=1 with irq=1 for 10 cycles → irq_pend stays 0, irq_ack never asserts. Drop kernel_id → ack within 2 cycles.
- jr_id=1 with jump_id=1 → pc_src=3. stall_lu alone → pc_we=0, flush_id=1, flush_if=0.
